mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter DATAWIDTH, 32, width of all address and data buses.
REQ-002 SHALL have port ARB_Clk_In  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port ARB_Reset_In  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port ARB_Ins_Req_In  input  1  instruction fetch request, held until served.
REQ-005 SHALL have port ARB_Ins_Addr_InBUS  input  DATAWIDTH  fetch address.
REQ-006 SHALL have port ARB_Ins_Valid_Out  output  1  one-cycle pulse: fetch data valid.
REQ-007 SHALL have port ARB_Ins_Readdata_OutBUS  output  DATAWIDTH  fetched instruction.
REQ-008 SHALL have port ARB_Dat_Req_In  input  1  data access request, held until served.
REQ-009 SHALL have port ARB_Dat_Write_In  input  1  1 = store, 0 = load.
REQ-010 SHALL have ports ARB_Dat_Addr_InBUS, ARB_Dat_Writedata_InBUS  input  DATAWIDTH  data address and store data.
REQ-011 SHALL have port ARB_Dat_Byteenable_InBUS  input  4  store/load byte lanes.
REQ-012 SHALL have ports ARB_Dat_Valid_Out  output  1  and ARB_Dat_Readdata_OutBUS  output  DATAWIDTH  as the data completion pulse and load data.
REQ-013 SHALL have memory ports ARB_Mem_Req_Out, ARB_Mem_Write_Out  output  1; ARB_Mem_Addr_OutBUS, ARB_Mem_Writedata_OutBUS  output  DATAWIDTH; ARB_Mem_Byteenable_OutBUS  output  4.
REQ-014 SHALL have memory ports ARB_Mem_Ready_In  input  1  (request accepted), ARB_Mem_Valid_In  input  1  (response/ack), and ARB_Mem_Readdata_InBUS  input  DATAWIDTH.
REQ-015 SHALL have port ARB_Grant_OutBUS  output  2  one-hot owner {dat,ins}; 2'b00 when no owner.

Function
REQ-016 SHALL implement FSM states IDLE, ISSUE, WAIT and RESP.
REQ-017 IDLE SHALL, on any request, select the owner (REQ-030/031), latch its address, writedata, byteenable and write flag into registers, and go to ISSUE; with no request it SHALL stay in IDLE.
REQ-018 ISSUE SHALL drive ARB_Mem_Req_Out=1 with latched fields stable until ARB_Mem_Ready_In=1, then go to WAIT.
REQ-019 If ARB_Mem_Ready_In and ARB_Mem_Valid_In are both 1 in ISSUE, the FSM SHALL capture the response and go directly to RESP.
REQ-020 WAIT SHALL, on ARB_Mem_Valid_In=1, register ARB_Mem_Readdata_InBUS and go to RESP.
REQ-021 RESP SHALL assert only the owner's Valid_Out for exactly one cycle, ignore all requests, then return to IDLE.
REQ-022 Minimum latency SHALL be 3 cycles from request sampled in IDLE to Valid_Out (Ready_In and Valid_In both 1 in the first ISSUE cycle).
REQ-023 Instruction transactions SHALL drive Write=0 and Byteenable=4'b1111; store readdata output SHALL hold its previous value.
REQ-024 A requester dropping Req mid-transaction SHALL NOT abort; the transaction completes and Valid_Out still pulses.
REQ-025 ARB_Mem_Valid_In outside WAIT (and outside the case in REQ-019) SHALL be ignored.
REQ-026 ARB_Grant_OutBUS SHALL be non-zero from ISSUE through RESP inclusive.

Reset
REQ-027 Asserting ARB_Reset_In low SHALL immediately force IDLE and drive every output and latched register to 0, including in-flight transactions, which are dropped.
REQ-028 After release, the first arbitration SHALL occur on the first rising edge with ARB_Reset_In high.
REQ-029 The round-robin last-grant register SHALL reset to data.

Configuration
REQ-030 Without MEM_ARBITER_RR_EN, simultaneous requests SHALL grant data (fixed priority).
REQ-031 With MEM_ARBITER_RR_EN, simultaneous requests SHALL grant the requester not granted last; a lone request SHALL always be granted.

Structure
REQ-032 Package mem_arbiter_pkg SHALL hold the state enum, the owner encoding, and the constant BE_ALL=4'b1111.
REQ-033 Grant selection SHALL be the single sub-module mem_arbiter_grant (combinational, macro-aware); all other logic SHALL stay in mem_arbiter.

Verification
REQ-034 Ins Req, addr 0x0000_0010, memory Ready/Valid immediately with data 0x0000_0013 -> Mem_Req cycle 1, Ins_Valid pulse cycle 3 with 0x0000_0013.
REQ-035 Both requests in the same cycle -> data served first, then ins; with MEM_ARBITER_RR_EN, first tie -> ins, second tie -> data.
REQ-036 Store addr 0x100, data 0xDEADBEEF, BE 4'b0011, Ready held low 4 cycles -> Mem fields stable for all 5 cycles, Dat_Valid after Valid_In.
REQ-037 Reset asserted in WAIT -> all outputs 0 asynchronously; a later Valid_In produces no Valid_Out.
REQ-038 Dat_Req dropped in WAIT -> Dat_Valid still pulses once; no second Mem_Req issued.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arbiter_pkg
//   Shared types and constants for the two-requester memory arbiter:
//   - state_e      : arbiter FSM states
//   - owner_e      : which requester owns the memory port (ins = 0, dat = 1)
//   - BE_ALL       : full-word byte enable used by instruction fetches
//   - grant_onehot : owner -> {dat,ins} one-hot grant vector
// -----------------------------------------------------------------------------
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    // OWN_INS is the all-zero encoding so a reset owner register reads as 0.
    typedef enum logic {
        OWN_INS = 1'b0,
        OWN_DAT = 1'b1
    } owner_e;

    localparam logic [3:0] BE_ALL = 4'b1111;

    function automatic logic [1:0] grant_onehot(input owner_e owner);
        return (owner == OWN_DAT) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/mem_arbiter_grant.sv
// -----------------------------------------------------------------------------
// mem_arbiter_grant
//   Combinational owner selection between the instruction and data requesters.
//   Build option MEM_ARBITER_RR_EN:
//     undefined : fixed priority, data wins a tie
//     defined   : round robin, a tie goes to the requester not granted last
//   A lone request is always granted in both builds.
// Ports
//   ins_req_i    : instruction requester is asking
//   dat_req_i    : data requester is asking
//   last_owner_i : owner granted most recently (round-robin build only)
//   owner_o      : selected owner; only meaningful when a request is present
// -----------------------------------------------------------------------------
module mem_arbiter_grant
    import mem_arbiter_pkg::*;
(
    input  logic   ins_req_i,
    input  logic   dat_req_i,
`ifdef MEM_ARBITER_RR_EN
    input  owner_e last_owner_i,
`endif
    output owner_e owner_o
);

    always_comb begin
        owner_o = OWN_DAT;
        if (ins_req_i && dat_req_i) begin
`ifdef MEM_ARBITER_RR_EN
            owner_o = (last_owner_i == OWN_DAT) ? OWN_INS : OWN_DAT;
`else
            owner_o = OWN_DAT;
`endif
        end else if (ins_req_i) begin
            owner_o = OWN_INS;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Shares one memory port between an instruction-fetch requester and a
//   load/store requester. One transaction at a time:
//     IDLE  -> pick owner, latch its command fields
//     ISSUE -> hold Mem_Req with stable fields until Mem_Ready
//     WAIT  -> wait for Mem_Valid, capture read data
//     RESP  -> load the owner's Valid_Out/Readdata registers (visible next cycle)
//   Build option MEM_ARBITER_RR_EN selects round-robin tie breaking instead of
//   fixed data priority (see mem_arbiter_grant).
// Ports
//   ARB_Clk_In, ARB_Reset_In          : clock, async active-low reset
//   ARB_Ins_*                         : fetch request/address, valid pulse, data
//   ARB_Dat_*                         : load/store request and fields, valid
//                                       pulse, load data
//   ARB_Mem_*                         : memory command (req/write/addr/wdata/be)
//                                       and response (ready/valid/readdata)
//   ARB_Grant_OutBUS                  : one-hot owner {dat,ins}, 0 when idle
// -----------------------------------------------------------------------------
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int DATAWIDTH = 32
)
(
    input  logic                 ARB_Clk_In,
    input  logic                 ARB_Reset_In,
    input  logic                 ARB_Ins_Req_In,
    input  logic [DATAWIDTH-1:0] ARB_Ins_Addr_InBUS,
    output logic                 ARB_Ins_Valid_Out,
    output logic [DATAWIDTH-1:0] ARB_Ins_Readdata_OutBUS,
    input  logic                 ARB_Dat_Req_In,
    input  logic                 ARB_Dat_Write_In,
    input  logic [DATAWIDTH-1:0] ARB_Dat_Addr_InBUS,
    input  logic [DATAWIDTH-1:0] ARB_Dat_Writedata_InBUS,
    input  logic [3:0]           ARB_Dat_Byteenable_InBUS,
    output logic                 ARB_Dat_Valid_Out,
    output logic [DATAWIDTH-1:0] ARB_Dat_Readdata_OutBUS,
    output logic                 ARB_Mem_Req_Out,
    output logic                 ARB_Mem_Write_Out,
    output logic [DATAWIDTH-1:0] ARB_Mem_Addr_OutBUS,
    output logic [DATAWIDTH-1:0] ARB_Mem_Writedata_OutBUS,
    output logic [3:0]           ARB_Mem_Byteenable_OutBUS,
    input  logic                 ARB_Mem_Ready_In,
    input  logic                 ARB_Mem_Valid_In,
    input  logic [DATAWIDTH-1:0] ARB_Mem_Readdata_InBUS,
    output logic [1:0]           ARB_Grant_OutBUS
);

    state_e               state_q, state_d;
    owner_e               owner_q, owner_d;
    logic [DATAWIDTH-1:0] addr_q, addr_d;
    logic [DATAWIDTH-1:0] wdata_q, wdata_d;
    logic [3:0]           be_q, be_d;
    logic                 write_q, write_d;
    logic [DATAWIDTH-1:0] rdata_q, rdata_d;
    logic                 ins_valid_q, ins_valid_d;
    logic                 dat_valid_q, dat_valid_d;
    logic [DATAWIDTH-1:0] ins_rdata_q, ins_rdata_d;
    logic [DATAWIDTH-1:0] dat_rdata_q, dat_rdata_d;
`ifdef MEM_ARBITER_RR_EN
    owner_e               last_q, last_d;
`endif

    logic   ins_req;
    logic   dat_req;
    owner_e sel_owner;

    // A requester still holds Req during the cycle its Valid_Out is high;
    // hide it for that one cycle so it is not served twice.
    assign ins_req = ARB_Ins_Req_In & ~ins_valid_q;
    assign dat_req = ARB_Dat_Req_In & ~dat_valid_q;

    mem_arbiter_grant u_grant (
        .ins_req_i    (ins_req),
        .dat_req_i    (dat_req),
`ifdef MEM_ARBITER_RR_EN
        .last_owner_i (last_q),
`endif
        .owner_o      (sel_owner)
    );

    // NOTE: every signal written here gets a default first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        write_d     = write_q;
        rdata_d     = rdata_q;
        ins_valid_d = 1'b0;
        dat_valid_d = 1'b0;
        ins_rdata_d = ins_rdata_q;
        dat_rdata_d = dat_rdata_q;
`ifdef MEM_ARBITER_RR_EN
        last_d      = last_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (ins_req || dat_req) begin
                    owner_d = sel_owner;
                    if (sel_owner == OWN_DAT) begin
                        addr_d  = ARB_Dat_Addr_InBUS;
                        wdata_d = ARB_Dat_Writedata_InBUS;
                        be_d    = ARB_Dat_Byteenable_InBUS;
                        write_d = ARB_Dat_Write_In;
                    end else begin
                        addr_d  = ARB_Ins_Addr_InBUS;
                        wdata_d = '0;
                        be_d    = BE_ALL;
                        write_d = 1'b0;
                    end
`ifdef MEM_ARBITER_RR_EN
                    last_d  = sel_owner;
`endif
                    state_d = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                if (ARB_Mem_Ready_In) begin
                    // A same-cycle response skips WAIT entirely.
                    if (ARB_Mem_Valid_In) begin
                        rdata_d = ARB_Mem_Readdata_InBUS;
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end

            ST_WAIT: begin
                if (ARB_Mem_Valid_In) begin
                    rdata_d = ARB_Mem_Readdata_InBUS;
                    state_d = ST_RESP;
                end
            end

            ST_RESP: begin
                if (owner_q == OWN_INS) begin
                    ins_valid_d = 1'b1;
                    ins_rdata_d = rdata_q;
                end else begin
                    dat_valid_d = 1'b1;
                    // Stores leave the previous load data on the bus.
                    if (!write_q) begin
                        dat_rdata_d = rdata_q;
                    end
                end
                state_d = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state flops use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop, independent of statement order.
    always_ff @(posedge ARB_Clk_In or negedge ARB_Reset_In) begin
        if (!ARB_Reset_In) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_INS;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            write_q     <= 1'b0;
            rdata_q     <= '0;
            ins_valid_q <= 1'b0;
            dat_valid_q <= 1'b0;
            ins_rdata_q <= '0;
            dat_rdata_q <= '0;
`ifdef MEM_ARBITER_RR_EN
            last_q      <= OWN_DAT;
`endif
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            write_q     <= write_d;
            rdata_q     <= rdata_d;
            ins_valid_q <= ins_valid_d;
            dat_valid_q <= dat_valid_d;
            ins_rdata_q <= ins_rdata_d;
            dat_rdata_q <= dat_rdata_d;
`ifdef MEM_ARBITER_RR_EN
            last_q      <= last_d;
`endif
        end
    end

    assign ARB_Mem_Req_Out           = (state_q == ST_ISSUE);
    assign ARB_Mem_Write_Out         = write_q;
    assign ARB_Mem_Addr_OutBUS       = addr_q;
    assign ARB_Mem_Writedata_OutBUS  = wdata_q;
    assign ARB_Mem_Byteenable_OutBUS = be_q;
    assign ARB_Grant_OutBUS          = (state_q == ST_IDLE) ? 2'b00 : grant_onehot(owner_q);
    assign ARB_Ins_Valid_Out         = ins_valid_q;
    assign ARB_Ins_Readdata_OutBUS   = ins_rdata_q;
    assign ARB_Dat_Valid_Out         = dat_valid_q;
    assign ARB_Dat_Readdata_OutBUS   = dat_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//   Directed bench for mem_arbiter. Expected completions (owner + data) are
//   queued when a request is driven and popped when a Valid_Out pulse appears.
//   Outputs are sampled 1 ns after the rising edge; inputs change right after.
//   Tie-break expectations follow MEM_ARBITER_RR_EN when it is defined.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ins_req;
    logic [31:0] ins_addr;
    logic        ins_valid;
    logic [31:0] ins_rdata;
    logic        dat_req;
    logic        dat_write;
    logic [31:0] dat_addr;
    logic [31:0] dat_wdata;
    logic [3:0]  dat_be;
    logic        dat_valid;
    logic [31:0] dat_rdata;
    logic        mem_req;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ready;
    logic        mem_valid;
    logic [31:0] mem_rdata;
    logic [1:0]  grant;

    always #5 clk = ~clk;

    mem_arbiter #(.DATAWIDTH(32)) dut (
        .ARB_Clk_In                (clk),
        .ARB_Reset_In              (rst_n),
        .ARB_Ins_Req_In            (ins_req),
        .ARB_Ins_Addr_InBUS        (ins_addr),
        .ARB_Ins_Valid_Out         (ins_valid),
        .ARB_Ins_Readdata_OutBUS   (ins_rdata),
        .ARB_Dat_Req_In            (dat_req),
        .ARB_Dat_Write_In          (dat_write),
        .ARB_Dat_Addr_InBUS        (dat_addr),
        .ARB_Dat_Writedata_InBUS   (dat_wdata),
        .ARB_Dat_Byteenable_InBUS  (dat_be),
        .ARB_Dat_Valid_Out         (dat_valid),
        .ARB_Dat_Readdata_OutBUS   (dat_rdata),
        .ARB_Mem_Req_Out           (mem_req),
        .ARB_Mem_Write_Out         (mem_write),
        .ARB_Mem_Addr_OutBUS       (mem_addr),
        .ARB_Mem_Writedata_OutBUS  (mem_wdata),
        .ARB_Mem_Byteenable_OutBUS (mem_be),
        .ARB_Mem_Ready_In          (mem_ready),
        .ARB_Mem_Valid_In          (mem_valid),
        .ARB_Mem_Readdata_InBUS    (mem_rdata),
        .ARB_Grant_OutBUS          (grant)
    );

    typedef struct {
        bit          is_dat;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] last_dat_rd = '0;
    int          mem_req_starts = 0;
    logic        mem_req_prev = 1'b0;

    // Counts memory commands started (rising edges of Mem_Req).
    always @(negedge clk) begin
        mem_req_prev <= mem_req;
        if (mem_req && !mem_req_prev) mem_req_starts <= mem_req_starts + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input bit is_dat, input logic [31:0] data);
        exp_t e;
        e.is_dat = is_dat;
        e.data   = data;
        sb.push_back(e);
    endtask

    // Pops the oldest expected completion and compares it with the pulse now visible.
    task automatic chk_resp(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, " unexpected_valid"}, {30'd0, dat_valid, ins_valid}, 32'd0);
        end else begin
            e = sb.pop_front();
            chk({tag, " valid_owner"}, {30'd0, dat_valid, ins_valid}, e.is_dat ? 32'd2 : 32'd1);
            chk({tag, " rdata"}, e.is_dat ? dat_rdata : ins_rdata, e.data);
        end
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int n = 0;
        while (!(ins_valid || dat_valid) && n < budget) begin
            tick();
            n++;
        end
        n_vec++;
        assert (ins_valid || dat_valid) else begin
            n_err++;
            $error("FAIL %s timeout: observed no Valid_Out within %0d cycles, expected a pulse", tag, budget);
        end
        if (ins_valid || dat_valid) chk_resp(tag);
    endtask

    // Acts as the memory: finds the command, checks its fields every ISSUE
    // cycle, accepts after rdly cycles and responds vdly cycles after accept.
    // Returns with the DUT in RESP.
    task automatic mem_txn(input string tag, input bit is_dat, input logic [31:0] a,
                           input bit w, input logic [31:0] wd, input logic [3:0] be,
                           input logic [31:0] rd, input int rdly, input int vdly);
        int n = 0;
        mem_ready = 1'b0;
        mem_valid = 1'b0;
        while (!mem_req && n < 8) begin
            tick();
            n++;
        end
        n_vec++;
        assert (mem_req) else begin
            n_err++;
            $error("FAIL %s timeout: observed no Mem_Req within 8 cycles, expected a request", tag);
        end
        if (mem_req) begin
            for (int i = 0; i <= rdly; i++) begin
                chk({tag, " mem_req"}, {31'd0, mem_req}, 32'd1);
                chk({tag, " grant"}, {30'd0, grant}, is_dat ? 32'd2 : 32'd1);
                chk({tag, " addr"}, mem_addr, a);
                chk({tag, " write"}, {31'd0, mem_write}, {31'd0, w});
                chk({tag, " be"}, {28'd0, mem_be}, {28'd0, be});
                if (w) chk({tag, " wdata"}, mem_wdata, wd);
                if (i < rdly) tick();
            end
            mem_ready = 1'b1;
            mem_valid = (vdly == 0);
            mem_rdata = rd;
            tick();
            mem_ready = 1'b0;
            mem_valid = 1'b0;
            if (vdly > 0) begin
                for (int i = 1; i < vdly; i++) tick();
                mem_valid = 1'b1;
                mem_rdata = rd;
                tick();
                mem_valid = 1'b0;
            end
        end
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        last_dat_rd = '0;
        tick();
    endtask

    initial begin
        bit first_dat;
        int snap;

        rst_n     = 1'b0;
        ins_req   = 1'b0;
        ins_addr  = '0;
        dat_req   = 1'b0;
        dat_write = 1'b0;
        dat_addr  = '0;
        dat_wdata = '0;
        dat_be    = '0;
        mem_ready = 1'b0;
        mem_valid = 1'b0;
        mem_rdata = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst grant", {30'd0, grant}, 32'd0);
        chk("rst valids", {30'd0, dat_valid, ins_valid}, 32'd0);
        chk("rst addr", mem_addr, 32'd0);
        chk("rst be", {28'd0, mem_be}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        tick();

        // Minimum latency fetch: Mem_Req in cycle 1, Ins_Valid in cycle 3
        ins_req   = 1'b1;
        ins_addr  = 32'h0000_0010;
        mem_ready = 1'b1;
        mem_valid = 1'b1;
        mem_rdata = 32'h0000_0013;
        push_exp(1'b0, 32'h0000_0013);
        tick();
        chk("lat c1 mem_req", {31'd0, mem_req}, 32'd1);
        chk("lat c1 addr", mem_addr, 32'h0000_0010);
        chk("lat c1 write", {31'd0, mem_write}, 32'd0);
        chk("lat c1 be", {28'd0, mem_be}, 32'h0000_000F);
        chk("lat c1 grant", {30'd0, grant}, 32'd1);
        tick();
        chk("lat c2 grant", {30'd0, grant}, 32'd1);
        chk("lat c2 mem_req", {31'd0, mem_req}, 32'd0);
        chk("lat c2 ins_valid", {31'd0, ins_valid}, 32'd0);
        tick();
        chk_resp("lat c3");
        ins_req   = 1'b0;
        mem_ready = 1'b0;
        mem_valid = 1'b0;
        tick();
        chk("lat c4 ins_valid", {31'd0, ins_valid}, 32'd0);
        chk("lat c4 grant", {30'd0, grant}, 32'd0);

        // Simultaneous requests; the first winner re-requests in its Valid cycle
        do_reset();
`ifdef MEM_ARBITER_RR_EN
        first_dat = 1'b0;
`else
        first_dat = 1'b1;
`endif
        ins_req   = 1'b1;
        ins_addr  = 32'h0000_0020;
        dat_req   = 1'b1;
        dat_write = 1'b0;
        dat_addr  = 32'h0000_0040;
        dat_be    = 4'b1111;
        if (first_dat) begin
            push_exp(1'b1, 32'h2222_0040);
            push_exp(1'b0, 32'h1111_0020);
            push_exp(1'b1, 32'h2222_0044);
            last_dat_rd = 32'h2222_0044;
            mem_txn("tie1", 1'b1, 32'h40, 1'b0, '0, 4'hF, 32'h2222_0040, 0, 0);
            wait_valid("tie1", 4);
            dat_addr = 32'h0000_0044;
            mem_txn("tie2", 1'b0, 32'h20, 1'b0, '0, 4'hF, 32'h1111_0020, 0, 1);
            wait_valid("tie2", 4);
            ins_req = 1'b0;
            mem_txn("tie3", 1'b1, 32'h44, 1'b0, '0, 4'hF, 32'h2222_0044, 1, 0);
            wait_valid("tie3", 4);
            dat_req = 1'b0;
        end else begin
            push_exp(1'b0, 32'h1111_0020);
            push_exp(1'b1, 32'h2222_0040);
            push_exp(1'b0, 32'h1111_0024);
            last_dat_rd = 32'h2222_0040;
            mem_txn("tie1", 1'b0, 32'h20, 1'b0, '0, 4'hF, 32'h1111_0020, 0, 0);
            wait_valid("tie1", 4);
            ins_addr = 32'h0000_0024;
            mem_txn("tie2", 1'b1, 32'h40, 1'b0, '0, 4'hF, 32'h2222_0040, 0, 1);
            wait_valid("tie2", 4);
            dat_req = 1'b0;
            mem_txn("tie3", 1'b0, 32'h24, 1'b0, '0, 4'hF, 32'h1111_0024, 1, 0);
            wait_valid("tie3", 4);
            ins_req = 1'b0;
        end
        tick();
        chk("tie idle valids", {30'd0, dat_valid, ins_valid}, 32'd0);

        // Store with Ready held low 4 cycles: fields stable for 5 ISSUE cycles
        dat_req   = 1'b1;
        dat_write = 1'b1;
        dat_addr  = 32'h0000_0100;
        dat_wdata = 32'hDEAD_BEEF;
        dat_be    = 4'b0011;
        push_exp(1'b1, last_dat_rd);
        mem_txn("store", 1'b1, 32'h100, 1'b1, 32'hDEAD_BEEF, 4'b0011, 32'h0BAD_0BAD, 4, 2);
        wait_valid("store", 4);
        dat_req   = 1'b0;
        dat_write = 1'b0;
        tick();
        chk("store pulse_end", {31'd0, dat_valid}, 32'd0);

        // Data requester drops Req while in WAIT
        dat_req  = 1'b1;
        dat_addr = 32'h0000_0200;
        dat_be   = 4'b1111;
        push_exp(1'b1, 32'h5555_AAAA);
        last_dat_rd = 32'h5555_AAAA;
        snap = mem_req_starts;
        tick();
        chk("drop issue", {31'd0, mem_req}, 32'd1);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        dat_req   = 1'b0;
        chk("drop wait mem_req", {31'd0, mem_req}, 32'd0);
        chk("drop wait grant", {30'd0, grant}, 32'd2);
        tick();
        tick();
        mem_valid = 1'b1;
        mem_rdata = 32'h5555_AAAA;
        tick();
        mem_valid = 1'b0;
        wait_valid("drop", 4);
        tick();
        chk("drop pulse_end", {31'd0, dat_valid}, 32'd0);
        repeat (3) tick();
        chk("drop mem_req_count", mem_req_starts, snap + 1);

        // Stray Mem_Valid while idle is ignored
        mem_valid = 1'b1;
        mem_rdata = 32'h0BAD_BAD0;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("stray valids", {30'd0, dat_valid, ins_valid}, 32'd0);
            chk("stray grant", {30'd0, grant}, 32'd0);
        end
        mem_valid = 1'b0;

        // Reset asserted in WAIT drops the transaction
        dat_req  = 1'b1;
        dat_addr = 32'h0000_0300;
        dat_be   = 4'b1100;
        tick();
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        chk("rstw grant", {30'd0, grant}, 32'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("rstw mem_req", {31'd0, mem_req}, 32'd0);
        chk("rstw grant0", {30'd0, grant}, 32'd0);
        chk("rstw addr", mem_addr, 32'd0);
        chk("rstw wdata", mem_wdata, 32'd0);
        chk("rstw be", {28'd0, mem_be}, 32'd0);
        chk("rstw valids", {30'd0, dat_valid, ins_valid}, 32'd0);
        chk("rstw ins_rdata", ins_rdata, 32'd0);
        chk("rstw dat_rdata", dat_rdata, 32'd0);
        dat_req = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        last_dat_rd = '0;
        mem_valid = 1'b1;
        mem_rdata = 32'h0000_0777;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rstw late_valid", {30'd0, dat_valid, ins_valid}, 32'd0);
        end
        mem_valid = 1'b0;

        // First arbitration on the first rising edge after reset release
        #2 rst_n = 1'b0;
        ins_req  = 1'b1;
        ins_addr = 32'h0000_0080;
        push_exp(1'b0, 32'h8080_0000);
        @(negedge clk) rst_n = 1'b1;
        tick();
        chk("rel mem_req", {31'd0, mem_req}, 32'd1);
        chk("rel grant", {30'd0, grant}, 32'd1);
        mem_txn("rel", 1'b0, 32'h80, 1'b0, '0, 4'hF, 32'h8080_0000, 1, 1);
        wait_valid("rel", 4);
        ins_req = 1'b0;
        tick();
        chk("rel pulse_end", {31'd0, ins_valid}, 32'd0);

        chk("sb drained", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
